multi_clock_divider: RTL and testbench
======================================

Name: multi_clock_divider

Overview:
Runtime-programmable, multi-channel clock divider. Generates NUM_CH independent divided clock outputs from one system clock. Each channel has its own divisor, duty cycle and enable. New settings take effect glitch-free at period boundaries. Used as a clock-enable and slow-clock source for peripherals (UART baud, LED blink, sampling strobes). It replaces fixed, elaboration-time frequency division.

Parameters:
NUM_CH, 2, number of independent divider channels (1..8)
DIV_WIDTH, 16, width of each channel's divisor and high-time fields
RESET_DIV, 10, divisor each channel uses after reset until its first load

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
enable  input  NUM_CH  per-channel run request; level-sensitive
load  input  NUM_CH  per-channel one-cycle strobe; captures divisor/highTime into the shadow registers
divisor  input  NUM_CH*DIV_WIDTH  channel c occupies bits [c*DIV_WIDTH +: DIV_WIDTH]; period in clk cycles
highTime  input  NUM_CH*DIV_WIDTH  same packing; high-phase length in clk cycles; 0 selects 50% duty
dividedClock  output  NUM_CH  registered divided clock per channel
tick  output  NUM_CH  one-cycle pulse, registered, coincident with each rising edge of dividedClock
running  output  NUM_CH  high while the channel is in RUN or STOPPING

Behaviour:
- Reset (rst_n=0, async): dividedClock=0, tick=0, running=0; all channels go to IDLE, counters 0; shadow divisor=RESET_DIV, shadow highTime=0; active divisor/highTime equal the shadow values.
- Effective values at commit (computed from shadow):
  - N = max(divisor, 2).
  - H = N>>1 if highTime==0, otherwise clamp(highTime, 1, N-1).
- Per-channel FSM, with counter cnt in 0..N-1:
  - IDLE: dividedClock=0. If enable=1, commit shadow to active, cnt<=0, go to RUN.
  - RUN: each cycle cnt<=(cnt==N-1)?0:cnt+1. Registered output dividedClock = (cnt<H) for the cnt value just entered.
    - First high cycle appears on the clk edge that leaves IDLE, i.e. 1 cycle after enable is sampled high.
    - tick=1 on the edges where cnt becomes 0.
  - Period boundary (cnt==N-1, cnt wraps to 0): commit shadow to active first, so the new N/H apply from the wrapped cycle. Mid-period loads never alter the current period.
  - RUN with enable=0: go to STOPPING (same counting rules, no new period started).
  - STOPPING: at the period boundary go to IDLE with dividedClock=0 and no tick. Output ends low, never truncated. If enable returns to 1 before the boundary, go back to RUN and continue without a gap.
- load while IDLE: captured into shadow; takes effect at the next enable.
- load and period boundary in the same cycle: the newly loaded value is committed at that boundary (load bypasses the shadow).
- Channels are fully independent. Simultaneous loads/enables on different channels have no interaction.
- Divided frequency = f_clk/N; exactly H high cycles per period; no pulses shorter than 1 clk.
- Mid-operation reset: immediate async clear to the reset state; the next period starts from IDLE.

Test Plan:
1. Reset, NUM_CH=2, no load, enable=2'b01 → ch0 period 10 cycles with 5 high; tick every 10 cycles; ch1 stays 0, running=2'b01.
2. ch0 load divisor=7, highTime=0 mid-period while running at N=10 → current 10-cycle period completes; following periods are 7 cycles with 3 high, 4 low; no glitch.
3. ch1 divisor=1, highTime=5, enable → clamped N=2, H=1: toggles every clk (f_clk/2); tick every 2 cycles.
4. ch0 divisor=4, highTime=3, enable dropped at cnt=1 → output completes the 3-high/1-low period; running falls with the boundary; output held 0; re-enable 5 cycles later restarts with first high 1 cycle after enable.
5. ch0 divisor=8, enable dropped then reasserted within the same period → no gap; period length stays 8.
6. rst_n pulsed low mid-high-phase on both channels → dividedClock, tick and running clear immediately; after release with enable held, channels restart at RESET_DIV=10.

Source files
------------

// File: rtl/multi_clock_divider.sv
// rtl/multi_clock_divider.sv - runtime-programmable multi-channel clock divider with glitch-free period-boundary updates
module multi_clock_divider #(
    parameter int NUM_CH    = 2,
    parameter int DIV_WIDTH = 16,
    parameter int RESET_DIV = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             enable,
    input  logic [NUM_CH-1:0]             load,
    input  logic [NUM_CH*DIV_WIDTH-1:0]   divisor,
    input  logic [NUM_CH*DIV_WIDTH-1:0]   highTime,
    output logic [NUM_CH-1:0]             dividedClock,
    output logic [NUM_CH-1:0]             tick,
    output logic [NUM_CH-1:0]             running
);

    typedef logic [DIV_WIDTH-1:0] div_t;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam div_t RST_DIV = div_t'(RESET_DIV);
    localparam div_t TWO     = div_t'(2);
    localparam div_t ONE     = div_t'(1);

    function automatic div_t eff_n(input div_t d);
        return (d < TWO) ? TWO : d;
    endfunction

    // Zero high time selects 50% duty; otherwise keep at least one low cycle.
    function automatic div_t eff_h(input div_t h, input div_t n);
        if (h == '0)
            return n >> 1;
        else if (h >= n)
            return n - ONE;
        else
            return h;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t state_q, state_d;
        div_t   cnt_q, cnt_d;
        div_t   n_q, n_d;
        div_t   h_q, h_d;
        div_t   sh_div_q, sh_ht_q;
        logic   clk_q, clk_d;
        logic   tick_q, tick_d;

        div_t   in_div, in_ht;
        div_t   com_n, com_h;
        logic   boundary;

        assign in_div = divisor[c*DIV_WIDTH +: DIV_WIDTH];
        assign in_ht  = highTime[c*DIV_WIDTH +: DIV_WIDTH];

        // A load coinciding with a commit point bypasses the shadow registers.
        assign com_n    = eff_n(load[c] ? in_div : sh_div_q);
        assign com_h    = eff_h(load[c] ? in_ht : sh_ht_q, com_n);
        assign boundary = (cnt_q == n_q - ONE);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                n_q      <= eff_n(RST_DIV);
                h_q      <= eff_h('0, eff_n(RST_DIV));
                sh_div_q <= RST_DIV;
                sh_ht_q  <= '0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                n_q     <= n_d;
                h_q     <= h_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
                if (load[c]) begin
                    sh_div_q <= in_div;
                    sh_ht_q  <= in_ht;
                end
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            n_d     = n_q;
            h_d     = h_q;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (enable[c]) begin
                        state_d = RUN;
                        n_d     = com_n;
                        h_d     = com_h;
                        clk_d   = 1'b1;
                        tick_d  = 1'b1;
                    end
                end
                RUN, STOPPING: begin
                    if (boundary) begin
                        cnt_d = '0;
                        if (enable[c]) begin
                            // New period: effective high time is always >= 1.
                            state_d = RUN;
                            n_d     = com_n;
                            h_d     = com_h;
                            clk_d   = 1'b1;
                            tick_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d   = cnt_q + ONE;
                        clk_d   = (cnt_q + ONE) < h_q;
                        state_d = enable[c] ? RUN : STOPPING;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign dividedClock[c] = clk_q;
        assign tick[c]         = tick_q;
        assign running[c]      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// tb/tb_multi_clock_divider.sv - self-checking bench for multi_clock_divider against a period-level model
module tb_multi_clock_divider;

    localparam int NCH = 2;
    localparam int W   = 16;

    logic             clk;
    logic             rst_n;
    logic [NCH-1:0]   enable;
    logic [NCH-1:0]   load;
    logic [NCH*W-1:0] divisor;
    logic [NCH*W-1:0] highTime;
    logic [NCH-1:0]   dividedClock;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   running;

    int errors = 0;
    int checks = 0;

    // Model: each period is a block of N cycles, first H high; rem = cycles left in the block.
    int m_n[NCH], m_h[NCH], m_rem[NCH], m_sd[NCH], m_sh[NCH];
    logic [NCH-1:0] e_clk, e_tick, e_run;

    multi_clock_divider #(.NUM_CH(NCH), .DIV_WIDTH(W), .RESET_DIV(10)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .divisor(divisor), .highTime(highTime),
        .dividedClock(dividedClock), .tick(tick), .running(running)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_rem[c] = 0; m_sd[c] = 10; m_sh[c] = 0; m_n[c] = 10; m_h[c] = 5;
        end
        e_clk = '0; e_tick = '0; e_run = '0;
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            int d, t, n, h;
            d = load[c] ? int'(divisor[c*W +: W]) : m_sd[c];
            t = load[c] ? int'(highTime[c*W +: W]) : m_sh[c];
            e_tick[c] = 1'b0;
            if (m_rem[c] > 1) begin
                m_rem[c]--;
            end else if (enable[c]) begin
                n = (d < 2) ? 2 : d;
                h = (t == 0) ? n / 2 : ((t >= n) ? n - 1 : t);
                m_n[c] = n; m_h[c] = h; m_rem[c] = n;
                e_tick[c] = 1'b1;
            end else begin
                m_rem[c] = 0;
            end
            if (load[c]) begin
                m_sd[c] = int'(divisor[c*W +: W]);
                m_sh[c] = int'(highTime[c*W +: W]);
            end
            e_run[c] = (m_rem[c] > 0);
            e_clk[c] = (m_rem[c] > 0) && ((m_n[c] - m_rem[c]) < m_h[c]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        enable = '0; load = '0; divisor = '0; highTime = '0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_ch(input int c, input int d, input int h);
        divisor[c*W +: W]  = W'(d);
        highTime[c*W +: W] = W'(h);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({dividedClock, tick, running} !== 6'b0) begin
            errors++;
            $display("FAIL reset got clk=%b tick=%b run=%b exp all 0", dividedClock, tick, running);
        end
    endtask

    task automatic test_default_period();
        int highs = 0, ticks = 0, ch1_high = 0;
        apply_reset();
        enable = 2'b01;
        for (int i = 1; i <= 30; i++) begin
            step();
            checks++;
            if ({dividedClock, tick, running} !== {e_clk, e_tick, e_run}) begin
                errors++;
                $display("FAIL default_period i=%0d got clk=%b tick=%b run=%b exp clk=%b tick=%b run=%b",
                         i, dividedClock, tick, running, e_clk, e_tick, e_run);
            end
            highs += int'(dividedClock[0]); ticks += int'(tick[0]); ch1_high += int'(dividedClock[1]);
        end
        checks++;
        if (highs != 15 || ticks != 3 || ch1_high != 0 || running !== 2'b01) begin
            errors++;
            $display("FAIL default_counts got highs=%0d ticks=%0d ch1=%0d run=%b exp 15 3 0 01",
                     highs, ticks, ch1_high, running);
        end
    endtask

    task automatic test_midperiod_load();
        int highs = 0;
        apply_reset();
        enable = 2'b01;
        for (int i = 1; i <= 26; i++) begin
            if (i == 4) begin load = 2'b01; set_ch(0, 7, 0); end
            step();
            load = '0;
            checks++;
            if ({dividedClock, tick, running} !== {e_clk, e_tick, e_run}) begin
                errors++;
                $display("FAIL midperiod_load i=%0d got clk=%b tick=%b exp clk=%b tick=%b",
                         i, dividedClock, tick, e_clk, e_tick);
            end
            if (i >= 11 && i <= 17) highs += int'(dividedClock[0]);
            if (i == 11 || i == 18 || i == 25) begin
                checks++;
                if (tick[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL midperiod_tick i=%0d got tick=%b exp 1", i, tick[0]);
                end
            end
        end
        checks++;
        if (highs != 3) begin
            errors++;
            $display("FAIL midperiod_highs got %0d exp 3", highs);
        end
    endtask

    task automatic test_clamp();
        apply_reset();
        load = 2'b10; set_ch(1, 1, 5);
        step();
        load = '0; enable = 2'b10;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (dividedClock[1] !== 1'(i % 2) || tick[1] !== 1'(i % 2) ||
                {dividedClock, tick, running} !== {e_clk, e_tick, e_run}) begin
                errors++;
                $display("FAIL clamp i=%0d got clk=%b tick=%b exp clk1=%0d tick1=%0d",
                         i, dividedClock, tick, i % 2, i % 2);
            end
        end
    endtask

    task automatic test_stop();
        apply_reset();
        load = 2'b01; set_ch(0, 4, 3);
        step();
        load = '0; enable = 2'b01;
        step();
        step();
        enable = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) enable = 2'b01;
            step();
            checks++;
            if ({dividedClock, tick, running} !== {e_clk, e_tick, e_run}) begin
                errors++;
                $display("FAIL stop i=%0d got clk=%b tick=%b run=%b exp clk=%b tick=%b run=%b",
                         i, dividedClock, tick, running, e_clk, e_tick, e_run);
            end
        end
        checks++;
        if (dividedClock[0] !== 1'b1 || tick[0] !== 1'b1 || running[0] !== 1'b1) begin
            errors++;
            $display("FAIL restart got clk=%b tick=%b run=%b exp 1 1 1", dividedClock[0], tick[0], running[0]);
        end
    endtask

    task automatic test_reenable();
        apply_reset();
        load = 2'b01; set_ch(0, 8, 0);
        step();
        load = '0; enable = 2'b01;
        for (int i = 1; i <= 20; i++) begin
            enable = (i == 3) ? 2'b00 : 2'b01;
            step();
            checks++;
            if ({dividedClock, tick, running} !== {e_clk, e_tick, e_run} || running[0] !== 1'b1 ||
                tick[0] !== ((i % 8) == 1)) begin
                errors++;
                $display("FAIL reenable i=%0d got clk=%b tick=%b run=%b exp clk=%b tick=%b run=%b",
                         i, dividedClock, tick, running, e_clk, e_tick, e_run);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        enable = 2'b11;
        step(); step(); step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({dividedClock, tick, running} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset got clk=%b tick=%b run=%b exp all 0", dividedClock, tick, running);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step();
            checks++;
            if ({dividedClock, tick, running} !== {e_clk, e_tick, e_run} ||
                tick !== (((i % 10) == 1) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL after_reset i=%0d got clk=%b tick=%b run=%b exp clk=%b tick=%b run=%b",
                         i, dividedClock, tick, running, e_clk, e_tick, e_run);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(7) == 0) enable[c] = ~enable[c];
                load[c] = ($urandom_range(9) == 0);
                set_ch(c, int'($urandom_range(12)), int'($urandom_range(14)));
            end
            step();
            checks++;
            if ({dividedClock, tick, running} !== {e_clk, e_tick, e_run}) begin
                errors++;
                $display("FAIL random i=%0d got clk=%b tick=%b run=%b exp clk=%b tick=%b run=%b",
                         i, dividedClock, tick, running, e_clk, e_tick, e_run);
            end
        end
        load = '0;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        enable = '0; load = '0; divisor = '0; highTime = '0;
        model_reset();
        test_reset();
        test_default_period();
        test_midperiod_load();
        test_clamp();
        test_stop();
        test_reenable();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
